// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm bank: channel state encoding,
// length-code width and ring-length conversion.
package alarm_pkg;

    localparam int LEN_CODE_W = 2;
    localparam int REMAIN_W   = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } alarm_state_e;

    // Ring length in seconds for a length code: (code + 1) * step.
    function automatic logic [REMAIN_W-1:0] len_secs(input logic [LEN_CODE_W-1:0] code,
                                                     input int unsigned step);
        int unsigned secs_s;
        secs_s = (32'(code) + 32'd1) * step;
        return REMAIN_W'(secs_s);
    endfunction

endpackage

// File: rtl/alarm_bank_if.sv
// Configuration bus of the alarm bank: channel write port with error
// strobe, and combinational read-back of one selected channel.
interface alarm_bank_if #(
    parameter int IDX_W   = 2,
    parameter int SEC_W   = 17,
    parameter int MUSIC_W = 2
);
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic               wr_arm;
    logic [SEC_W-1:0]   wr_sec;
    logic [1:0]         wr_len;
    logic [MUSIC_W-1:0] wr_music;
    logic               wr_err;

    logic [IDX_W-1:0]   rd_idx;
    logic               rd_arm;
    logic [SEC_W-1:0]   rd_sec;
    logic [1:0]         rd_len;
    logic [MUSIC_W-1:0] rd_music;
    logic [1:0]         rd_state;

    modport master (
        output wr_en, wr_idx, wr_arm, wr_sec, wr_len, wr_music, rd_idx,
        input  wr_err, rd_arm, rd_sec, rd_len, rd_music, rd_state
    );

    modport slave (
        input  wr_en, wr_idx, wr_arm, wr_sec, wr_len, wr_music, rd_idx,
        output wr_err, rd_arm, rd_sec, rd_len, rd_music, rd_state
    );
endinterface

// File: rtl/alarm_bank_chk.sv
// Assertion checker bound into alarm_bank: parameter sanity and
// consistency between the registered ring outputs.
module alarm_bank_chk #(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = 2,
    parameter int LEN_STEP   = 15,
    parameter int MAX_SNOOZE = 3
) (
    input logic                  clk,
    input logic                  rst,
    input logic [NUM_ALARMS-1:0] ringing,
    input logic                  ring,
    input logic [IDX_W-1:0]      ring_idx
);

    a_len_fits: assert property (@(posedge clk) (LEN_STEP * 32'd4) <= 32'd127);

    a_limit_sane: assert property (@(posedge clk) MAX_SNOOZE >= 32'd1);

    a_ring_or: assert property (@(posedge clk) disable iff (rst) ring == (|ringing));

    a_idx_idle: assert property (@(posedge clk) disable iff (rst) !ring |-> (ring_idx == '0));

endmodule

// File: rtl/alarm_channel.sv
// One alarm channel: configuration registers, IDLE/RINGING/SNOOZED FSM,
// ring and snooze countdowns. ALARM_SNOOZE_LIMIT_EN adds a snooze limit.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int SEC_W       = 17,
    parameter int MUSIC_W     = 2,
    parameter int LEN_STEP    = 15,
    parameter int SNOOZE_SECS = 300
`ifdef ALARM_SNOOZE_LIMIT_EN
    ,
    parameter int MAX_SNOOZE  = 3
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_1hz,
    input  logic [SEC_W-1:0]      cur_sec,
    input  logic                  wr_hit,
    input  logic                  wr_arm,
    input  logic [SEC_W-1:0]      wr_sec,
    input  logic [LEN_CODE_W-1:0] wr_len,
    input  logic [MUSIC_W-1:0]    wr_music,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic                  arm,
    output logic [SEC_W-1:0]      sec,
    output logic [LEN_CODE_W-1:0] len,
    output logic [MUSIC_W-1:0]    music,
    output alarm_state_e          state,
    output logic                  ring_nxt
);

    localparam int SNZ_W = $clog2(SNOOZE_SECS + 1);

    logic                  arm_r;
    logic [SEC_W-1:0]      sec_r;
    logic [LEN_CODE_W-1:0] len_r;
    logic [MUSIC_W-1:0]    music_r;
    alarm_state_e          state_r;
    alarm_state_e          state_s;
    logic [REMAIN_W-1:0]   remain_r;
    logic [REMAIN_W-1:0]   remain_s;
    logic [SNZ_W-1:0]      snz_r;
    logic [SNZ_W-1:0]      snz_s;
    logic                  match_s;
    logic                  limit_hit_s;

`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_SNOOZE + 1);
    logic [CNT_W-1:0] snz_cnt_r;
    logic [CNT_W-1:0] snz_cnt_s;

    // Snooze count: cleared whenever the channel lands in IDLE, bumped on each snooze.
    always_comb begin
        snz_cnt_s = snz_cnt_r;
        if (state_s == ST_IDLE) begin
            snz_cnt_s = '0;
        end else if (state_r == ST_RINGING && state_s == ST_SNOOZED) begin
            snz_cnt_s = snz_cnt_r + CNT_W'(32'd1);
        end else begin
            snz_cnt_s = snz_cnt_r;
        end
    end

    assign limit_hit_s = (32'(snz_cnt_r) >= MAX_SNOOZE);

    // Snooze count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            snz_cnt_r <= '0;
        end else begin
            snz_cnt_r <= snz_cnt_s;
        end
    end
`else
    assign limit_hit_s = 1'b0;
`endif

    assign match_s = tick_1hz && arm_r && (cur_sec == sec_r);

    // Next-state logic; write beats dismiss beats snooze beats tick.
    always_comb begin
        state_s  = state_r;
        remain_s = remain_r;
        snz_s    = snz_r;
        if (wr_hit) begin
            state_s  = ST_IDLE;
            remain_s = '0;
            snz_s    = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (match_s && !dismiss) begin
                        state_s  = ST_RINGING;
                        remain_s = len_secs(len_r, LEN_STEP);
                    end else begin
                        state_s  = ST_IDLE;
                    end
                end
                ST_RINGING: begin
                    if (dismiss || (snooze && limit_hit_s)) begin
                        state_s  = ST_IDLE;
                        remain_s = '0;
                    end else if (snooze) begin
                        state_s  = ST_SNOOZED;
                        remain_s = '0;
                        snz_s    = SNZ_W'(SNOOZE_SECS);
                    end else if (tick_1hz) begin
                        if (remain_r <= 7'd1) begin
                            state_s  = ST_IDLE;
                            remain_s = '0;
                        end else begin
                            remain_s = remain_r - 7'd1;
                        end
                    end else begin
                        state_s = ST_RINGING;
                    end
                end
                ST_SNOOZED: begin
                    if (dismiss) begin
                        state_s = ST_IDLE;
                        snz_s   = '0;
                    end else if (tick_1hz) begin
                        if (snz_r <= SNZ_W'(32'd1)) begin
                            state_s  = ST_RINGING;
                            remain_s = len_secs(len_r, LEN_STEP);
                            snz_s    = '0;
                        end else begin
                            snz_s = snz_r - SNZ_W'(32'd1);
                        end
                    end else begin
                        state_s = ST_SNOOZED;
                    end
                end
                default: begin
                    state_s  = ST_IDLE;
                    remain_s = '0;
                    snz_s    = '0;
                end
            endcase
        end
    end

    // Configuration, state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_r    <= 1'b0;
            sec_r    <= '0;
            len_r    <= '0;
            music_r  <= '0;
            state_r  <= ST_IDLE;
            remain_r <= '0;
            snz_r    <= '0;
        end else begin
            if (wr_hit) begin
                arm_r   <= wr_arm;
                sec_r   <= wr_sec;
                len_r   <= wr_len;
                music_r <= wr_music;
            end
            state_r  <= state_s;
            remain_r <= remain_s;
            snz_r    <= snz_s;
        end
    end

    // Encoding 3 is unreachable but reads back as IDLE.
    always_comb begin
        case (state_r)
            ST_RINGING: state = ST_RINGING;
            ST_SNOOZED: state = ST_SNOOZED;
            default:    state = ST_IDLE;
        endcase
    end

    assign arm      = arm_r;
    assign sec      = sec_r;
    assign len      = len_r;
    assign music    = music_r;
    assign ring_nxt = (state_s == ST_RINGING);

endmodule

// File: rtl/alarm_bank.sv
// N-channel alarm engine: write decode, read-back mux and lowest-index
// ring arbitration. ALARM_SNOOZE_LIMIT_EN enables the per-channel snooze limit.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS  = 4,
    parameter int IDX_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
    parameter int SEC_W       = 17,
    parameter int DAY_SECS    = 86400,
    parameter int MUSIC_W     = 2,
    parameter int LEN_STEP    = 15,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_1hz,
    input  logic [SEC_W-1:0]      cur_sec,
    alarm_bank_if.slave           bus,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic                  ring,
    output logic [IDX_W-1:0]      ring_idx,
    output logic [MUSIC_W-1:0]    ring_music
);

    logic                  wr_ok_s;
    logic [NUM_ALARMS-1:0] wr_hit_s;
    logic [NUM_ALARMS-1:0] ring_nxt_s;
    logic                  arm_a   [NUM_ALARMS];
    logic [SEC_W-1:0]      sec_a   [NUM_ALARMS];
    logic [LEN_CODE_W-1:0] len_a   [NUM_ALARMS];
    logic [MUSIC_W-1:0]    music_a [NUM_ALARMS];
    alarm_state_e          state_a [NUM_ALARMS];

    logic [IDX_W-1:0]      enc_idx_s;
    logic [MUSIC_W-1:0]    enc_music_s;
    logic [NUM_ALARMS-1:0] ringing_r;
    logic                  ring_r;
    logic [IDX_W-1:0]      ring_idx_r;
    logic [MUSIC_W-1:0]    ring_music_r;
    logic                  wr_err_r;

    assign wr_ok_s = (bus.wr_sec < SEC_W'(DAY_SECS));

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
        assign wr_hit_s[g] = bus.wr_en && wr_ok_s && (bus.wr_idx == IDX_W'(g));

        alarm_channel #(
            .SEC_W       (SEC_W),
            .MUSIC_W     (MUSIC_W),
            .LEN_STEP    (LEN_STEP),
            .SNOOZE_SECS (SNOOZE_SECS)
`ifdef ALARM_SNOOZE_LIMIT_EN
            ,
            .MAX_SNOOZE  (MAX_SNOOZE)
`endif
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick_1hz (tick_1hz),
            .cur_sec  (cur_sec),
            .wr_hit   (wr_hit_s[g]),
            .wr_arm   (bus.wr_arm),
            .wr_sec   (bus.wr_sec),
            .wr_len   (bus.wr_len),
            .wr_music (bus.wr_music),
            .snooze   (snooze),
            .dismiss  (dismiss),
            .arm      (arm_a[g]),
            .sec      (sec_a[g]),
            .len      (len_a[g]),
            .music    (music_a[g]),
            .state    (state_a[g]),
            .ring_nxt (ring_nxt_s[g])
        );
    end

    // Read-back mux; out-of-range indices read as zero.
    always_comb begin
        bus.rd_arm   = 1'b0;
        bus.rd_sec   = '0;
        bus.rd_len   = '0;
        bus.rd_music = '0;
        bus.rd_state = 2'd0;
        if (32'(bus.rd_idx) < NUM_ALARMS) begin
            bus.rd_arm   = arm_a[bus.rd_idx];
            bus.rd_sec   = sec_a[bus.rd_idx];
            bus.rd_len   = len_a[bus.rd_idx];
            bus.rd_music = music_a[bus.rd_idx];
            bus.rd_state = state_a[bus.rd_idx];
        end else begin
            bus.rd_state = 2'd0;
        end
    end

    // Fixed-priority encoder on next-cycle ringing so it registers alongside the flags.
    always_comb begin
        enc_idx_s   = '0;
        enc_music_s = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (ring_nxt_s[i]) begin
                enc_idx_s   = IDX_W'(i);
                enc_music_s = music_a[i];
            end else begin
                enc_idx_s   = enc_idx_s;
            end
        end
    end

    // Registered ring outputs and write-error strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            ringing_r    <= '0;
            ring_r       <= 1'b0;
            ring_idx_r   <= '0;
            ring_music_r <= '0;
            wr_err_r     <= 1'b0;
        end else begin
            ringing_r    <= ring_nxt_s;
            ring_r       <= |ring_nxt_s;
            ring_idx_r   <= enc_idx_s;
            ring_music_r <= enc_music_s;
            wr_err_r     <= bus.wr_en && !wr_ok_s;
        end
    end

    assign ringing     = ringing_r;
    assign ring        = ring_r;
    assign ring_idx    = ring_idx_r;
    assign ring_music  = ring_music_r;
    assign bus.wr_err  = wr_err_r;

    alarm_bank_chk #(
        .NUM_ALARMS (NUM_ALARMS),
        .IDX_W      (IDX_W),
        .LEN_STEP   (LEN_STEP),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .ringing  (ringing_r),
        .ring     (ring_r),
        .ring_idx (ring_idx_r)
    );

endmodule
